ps2_mouse_sequencer: RTL and testbench

PS2_MOUSE_SEQUENCER -- requirements
Module: ps2_mouse_sequencer

---
 rtl/ps2_mouse_sequencer_if.sv | 20 ++
 rtl/ps2_mouse_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ps2_mouse_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_sequencer_if.sv
// Byte-level handshake between the PS/2 mouse sequencer and the line transceiver.
// The sequencer is the master: it issues command bytes and consumes received bytes.
interface ps2_mouse_sequencer_if;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       tx_error;
    logic       rx_valid;
    logic [7:0] rx_byte;

    modport master (
        output tx_start, tx_byte,
        input  tx_done, tx_error, rx_valid, rx_byte
    );

    modport slave (
        input  tx_start, tx_byte,
        output tx_done, tx_error, rx_valid, rx_byte
    );
endinterface

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse bring-up sequencer: reset / BAT / ID / enable-reporting handshake with
// retries and timeouts, then framing of 3-byte stream-mode movement packets.
module ps2_mouse_sequencer #(
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                         qzt_clk,
    input  logic                         reset,
    input  logic                         trigger,
    ps2_mouse_sequencer_if.master        ps2,
    output logic [7:0]                   status_pck_1,
    output logic [7:0]                   xm_pck_2,
    output logic [7:0]                   ym_pck_3,
    output logic                         pkt_valid,
    output logic                         ready,
    output logic                         error,
    output logic [3:0]                   state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_SEND_RST     = 4'd1,
        S_WAIT_ACK_RST = 4'd2,
        S_WAIT_BAT     = 4'd3,
        S_WAIT_ID      = 4'd4,
        S_SEND_EN      = 4'd5,
        S_WAIT_ACK_EN  = 4'd6,
        S_STREAM       = 4'd7,
        S_FAIL         = 4'd8
    } state_t;

    localparam logic [25:0] TMO_LAST = 26'(TIMEOUT_CYCLES - 1);
    localparam logic [25:0] TMO_MAX  = '1;

    state_t      state, state_nxt;
    logic        trig_q, trig_edge;
    logic [25:0] tmo_cnt;
    logic [7:0]  retry_cnt, retry_inc;
    logic        ack_seen;
    logic [1:0]  pkt_idx;
    logic [7:0]  pkt_b0, pkt_b1;
    logic        timed_out, attempt_failed, byte_accepted, done_accepted, pkt_drop;

    assign trig_edge = trigger & ~trig_q;
    assign timed_out = (tmo_cnt >= TMO_LAST);
    assign retry_inc = retry_cnt + 8'd1;

    assign ps2.tx_start = (state == S_SEND_RST) || (state == S_SEND_EN);
    assign ready        = (state == S_STREAM);
    assign error        = (state == S_FAIL);
    assign state_dbg    = state;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt      = state;
        attempt_failed = 1'b0;
        byte_accepted  = 1'b0;
        done_accepted  = 1'b0;
        pkt_drop       = 1'b0;

        unique case (state)
            S_IDLE, S_FAIL: begin
            end
            S_SEND_RST: state_nxt = S_WAIT_ACK_RST;
            S_SEND_EN:  state_nxt = S_WAIT_ACK_EN;
            S_WAIT_ACK_RST, S_WAIT_ACK_EN: begin
                // The ACK byte only counts once the transmitter has confirmed the command.
                if (ps2.tx_error) begin
                    attempt_failed = 1'b1;
                end else if (ps2.rx_valid) begin
                    if (ack_seen && ps2.rx_byte == 8'hFA) begin
                        byte_accepted = 1'b1;
                        state_nxt     = (state == S_WAIT_ACK_RST) ? S_WAIT_BAT : S_STREAM;
                    end else begin
                        attempt_failed = 1'b1;
                    end
                end else if (ps2.tx_done && !ack_seen) begin
                    done_accepted = 1'b1;
                end else if (timed_out) begin
                    attempt_failed = 1'b1;
                end
            end
            S_WAIT_BAT, S_WAIT_ID: begin
                if (ps2.tx_error) begin
                    attempt_failed = 1'b1;
                end else if (ps2.rx_valid) begin
                    if (ps2.rx_byte == ((state == S_WAIT_BAT) ? 8'hAA : 8'h00)) begin
                        byte_accepted = 1'b1;
                        state_nxt     = (state == S_WAIT_BAT) ? S_WAIT_ID : S_SEND_EN;
                    end else begin
                        attempt_failed = 1'b1;
                    end
                end else if (timed_out) begin
                    attempt_failed = 1'b1;
                end
            end
            S_STREAM: begin
                if (ps2.rx_valid)
                    byte_accepted = (pkt_idx != 2'd0) || ps2.rx_byte[3];
                else
                    pkt_drop = (pkt_idx != 2'd0) && timed_out;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (attempt_failed)
            state_nxt = (32'(retry_inc) < 32'(MAX_RETRIES)) ? S_SEND_RST : S_FAIL;

        // A trigger edge overrides whatever the current state was doing this cycle.
        if (trig_edge) begin
            state_nxt      = S_SEND_RST;
            attempt_failed = 1'b0;
            byte_accepted  = 1'b0;
            done_accepted  = 1'b0;
            pkt_drop       = 1'b0;
        end
    end

    always_ff @(posedge qzt_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        // trig_q follows trigger through reset so a level held high cannot auto-start.
        trig_q <= trigger;
        if (reset) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            retry_cnt    <= '0;
            ack_seen     <= 1'b0;
            pkt_idx      <= '0;
            pkt_b0       <= '0;
            pkt_b1       <= '0;
            ps2.tx_byte  <= 8'h00;
            status_pck_1 <= 8'h00;
            xm_pck_2     <= 8'h00;
            ym_pck_3     <= 8'h00;
            pkt_valid    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pkt_valid <= 1'b0;

            if (trig_edge)
                retry_cnt <= '0;
            else if (attempt_failed)
                retry_cnt <= retry_inc;

            if (state_nxt == S_SEND_RST)
                ps2.tx_byte <= 8'hFF;
            else if (state_nxt == S_SEND_EN)
                ps2.tx_byte <= 8'hF4;

            if (state_nxt != state || byte_accepted || done_accepted || pkt_drop)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 26'd1;

            if (state_nxt != state)
                ack_seen <= 1'b0;
            else if (done_accepted)
                ack_seen <= 1'b1;

            // Stream framing: bytes are staged until the third one publishes the packet.
            if (state != S_STREAM || trig_edge) begin
                pkt_idx <= 2'd0;
            end else if (byte_accepted) begin
                unique case (pkt_idx)
                    2'd0: begin
                        pkt_b0  <= ps2.rx_byte;
                        pkt_idx <= 2'd1;
                    end
                    2'd1: begin
                        pkt_b1  <= ps2.rx_byte;
                        pkt_idx <= 2'd2;
                    end
                    default: begin
                        status_pck_1 <= pkt_b0;
                        xm_pck_2     <= pkt_b1;
                        ym_pck_3     <= ps2.rx_byte;
                        pkt_valid    <= 1'b1;
                        pkt_idx      <= 2'd0;
                    end
                endcase
            end else if (pkt_drop) begin
                pkt_idx <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// Self-checking bench for ps2_mouse_sequencer: init handshake, retries, timeouts,
// table-driven packet framing and a randomized stream against a queue-based model.
module tb_ps2_mouse_sequencer;

    localparam int TMO = 100;

    logic       clk;
    logic       reset;
    logic       trigger;
    logic [7:0] status_pck_1, xm_pck_2, ym_pck_3;
    logic       pkt_valid, ready, error;
    logic [3:0] state_dbg;

    ps2_mouse_sequencer_if dut_if ();

    ps2_mouse_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (3)
    ) dut (
        .qzt_clk      (clk),
        .reset        (reset),
        .trigger      (trigger),
        .ps2          (dut_if),
        .status_pck_1 (status_pck_1),
        .xm_pck_2     (xm_pck_2),
        .ym_pck_3     (ym_pck_3),
        .pkt_valid    (pkt_valid),
        .ready        (ready),
        .error        (error),
        .state_dbg    (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] tx_log[$];
    int         pkt_cnt = 0;

    // Record every command byte the DUT launches and every packet pulse.
    always @(negedge clk) begin
        if (dut_if.tx_start) tx_log.push_back(dut_if.tx_byte);
        if (pkt_valid) pkt_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        dut_if.rx_valid = 1'b1;
        dut_if.rx_byte  = b;
        tick(1);
        dut_if.rx_valid = 1'b0;
    endtask

    task automatic send_done();
        dut_if.tx_done = 1'b1;
        tick(1);
        dut_if.tx_done = 1'b0;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
    endtask

    task automatic expect_tx(input string name, input logic [7:0] exp, input int budget);
        int waited = 0;
        while (tx_log.size() == 0 && waited < budget) begin
            tick(1);
            waited++;
        end
        check({name, "_present"}, 32'(tx_log.size() != 0), 32'd1);
        if (tx_log.size() != 0) check({name, "_byte"}, 32'(tx_log.pop_front()), 32'(exp));
    endtask

    task automatic full_init(input string tag);
        tx_log.delete();
        pulse_trigger();
        expect_tx({tag, "_ff"}, 8'hFF, 10);
        send_done();
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h00);
        expect_tx({tag, "_f4"}, 8'hF4, 10);
        send_done();
        send_rx(8'hFA);
        tick(1);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_state"}, 32'(state_dbg), 32'd7);
    endtask

    task automatic check_pkt(input string name, input logic [23:0] exp);
        check(name, {8'h00, status_pck_1, xm_pck_2, ym_pck_3}, {8'h00, exp});
    endtask

    typedef struct {
        logic [7:0]  rx;
        logic        pulse;
        logic [23:0] pkt;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int         waited;
        int         pkt_before;
        logic [7:0] b;
        logic [7:0] pend[$];
        logic [23:0] last_pkt;
        logic       exp_pulse;
        int         gap;

        reset = 1'b1;
        trigger = 1'b0;
        dut_if.tx_done = 1'b0;
        dut_if.tx_error = 1'b0;
        dut_if.rx_valid = 1'b0;
        dut_if.rx_byte = 8'h00;

        vecs[0]  = '{8'h08, 1'b0, 24'h000000};
        vecs[1]  = '{8'h05, 1'b0, 24'h000000};
        vecs[2]  = '{8'hFB, 1'b1, 24'h0805FB};
        vecs[3]  = '{8'h00, 1'b0, 24'h0805FB};
        vecs[4]  = '{8'hF7, 1'b0, 24'h0805FB};
        vecs[5]  = '{8'hC9, 1'b0, 24'h0805FB};
        vecs[6]  = '{8'h80, 1'b0, 24'h0805FB};
        vecs[7]  = '{8'h7F, 1'b1, 24'hC9807F};
        vecs[8]  = '{8'h18, 1'b0, 24'hC9807F};
        vecs[9]  = '{8'h00, 1'b0, 24'hC9807F};
        vecs[10] = '{8'h08, 1'b1, 24'h180008};

        // Reset state
        tick(3);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_tx_start", 32'(dut_if.tx_start), 32'd0);
        check("rst_tx_byte", 32'(dut_if.tx_byte), 32'd0);
        check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check_pkt("rst_pkt", 24'h000000);
        reset = 1'b0;
        tick(2);

        // IDLE ignores received bytes and does not start by itself
        send_rx(8'hFA);
        send_rx(8'h08);
        tick(5);
        check("idle_state", 32'(state_dbg), 32'd0);
        check("idle_no_tx", 32'(tx_log.size()), 32'd0);

        // Withheld BAT: retransmission of 0xFF after TIMEOUT_CYCLES in WAIT_BAT
        tx_log.delete();
        pulse_trigger();
        check("trig_state", 32'(state_dbg), 32'd1);
        expect_tx("tmo_first", 8'hFF, 10);
        send_done();
        send_rx(8'hFA);
        check("tmo_in_bat", 32'(state_dbg), 32'd3);
        waited = 0;
        while (!dut_if.tx_start && waited < 300) begin
            tick(1);
            waited++;
        end
        check("tmo_retx_seen", 32'(dut_if.tx_start), 32'd1);
        check("tmo_latency", 32'(waited), 32'(TMO));
        expect_tx("tmo_retx", 8'hFF, 5);
        send_done();
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h00);
        expect_tx("tmo_f4", 8'hF4, 10);
        send_done();
        send_rx(8'hFA);
        tick(1);
        check("tmo_ready", 32'(ready), 32'd1);
        check("tmo_state", 32'(state_dbg), 32'd7);

        // Table-driven packet framing
        for (int i = 0; i < 11; i++) begin
            send_rx(vecs[i].rx);
            check($sformatf("vec%0d_pulse", i), 32'(pkt_valid), 32'(vecs[i].pulse));
            check_pkt($sformatf("vec%0d_pkt", i), vecs[i].pkt);
        end
        tick(1);
        check("vec_pulse_one_cycle", 32'(pkt_valid), 32'd0);

        // Partial packet dropped after the inter-byte timeout
        send_rx(8'h08);
        send_rx(8'h05);
        tick(TMO + 10);
        send_rx(8'h00);
        check("drop_no_pulse", 32'(pkt_valid), 32'd0);
        check("drop_stream", 32'(ready), 32'd1);
        send_rx(8'h08);
        send_rx(8'h01);
        send_rx(8'h02);
        check("drop_new_pulse", 32'(pkt_valid), 32'd1);
        check_pkt("drop_new_pkt", 24'h080102);

        // Randomized stream against a queue-based framing model
        last_pkt = 24'h080102;
        for (int i = 0; i < 150; i++) begin
            b = 8'($urandom);
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(130, 160) : $urandom_range(0, 3);
            if (gap > 0) tick(gap);
            if (gap >= TMO) pend.delete();
            exp_pulse = 1'b0;
            if (pend.size() != 0 || b[3]) pend.push_back(b);
            if (pend.size() == 3) begin
                exp_pulse = 1'b1;
                last_pkt = {pend[0], pend[1], pend[2]};
                pend.delete();
            end
            send_rx(b);
            check($sformatf("rnd%0d_pulse", i), 32'(pkt_valid), 32'(exp_pulse));
            check_pkt($sformatf("rnd%0d_pkt", i), last_pkt);
        end

        // Trigger edge and third byte in the same cycle: trigger wins
        tick(TMO + 20);
        send_rx(8'h08);
        send_rx(8'h05);
        tx_log.delete();
        trigger = 1'b1;
        dut_if.rx_valid = 1'b1;
        dut_if.rx_byte = 8'hFB;
        tick(1);
        trigger = 1'b0;
        dut_if.rx_valid = 1'b0;
        check("race_no_pulse", 32'(pkt_valid), 32'd0);
        check("race_state", 32'(state_dbg), 32'd1);
        check("race_ready", 32'(ready), 32'd0);
        check_pkt("race_pkt_held", last_pkt);

        // Bad ACK on every attempt: three 0xFF transmissions, then FAIL
        for (int a = 0; a < 3; a++) begin
            expect_tx($sformatf("bad_ack_ff%0d", a), 8'hFF, 10);
            send_done();
            send_rx(8'hFE);
        end
        tick(20);
        check("bad_ack_no_more_tx", 32'(tx_log.size()), 32'd0);
        check("bad_ack_error", 32'(error), 32'd1);
        check("bad_ack_state", 32'(state_dbg), 32'd8);
        check("bad_ack_ready", 32'(ready), 32'd0);

        // FAIL ignores received bytes
        send_rx(8'hFA);
        send_rx(8'hAA);
        tick(3);
        check("fail_hold_state", 32'(state_dbg), 32'd8);
        check("fail_no_tx", 32'(tx_log.size()), 32'd0);

        // tx_error counts as a failed attempt and triggers a resend
        tx_log.delete();
        pulse_trigger();
        expect_tx("txerr_first", 8'hFF, 10);
        dut_if.tx_error = 1'b1;
        tick(1);
        dut_if.tx_error = 1'b0;
        expect_tx("txerr_retry", 8'hFF, 10);

        // Reset mid-packet discards everything
        full_init("reinit");
        send_rx(8'h08);
        send_rx(8'h05);
        pkt_before = pkt_cnt;
        reset = 1'b1;
        tick(1);
        check("midrst_pkt_valid", 32'(pkt_valid), 32'd0);
        check_pkt("midrst_pkt", 24'h000000);
        check("midrst_state", 32'(state_dbg), 32'd0);
        check("midrst_tx_byte", 32'(dut_if.tx_byte), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        tx_log.delete();
        send_rx(8'hFB);
        tick(20);
        check("midrst_no_pkt", 32'(pkt_cnt), 32'(pkt_before));
        check("midrst_no_autostart", 32'(state_dbg), 32'd0);
        check("midrst_no_tx", 32'(tx_log.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
